// File: rtl/stack_call_sequencer.sv
// Sequencer for PUSH/POP/CALL/RET: one handshaked memory access per operation,
// then a single commit cycle that strobes the SP/PC registers, or a one-cycle fault.
module stack_call_sequencer #(
  parameter logic [15:0] STACK_TOP   = 16'h0190,
  parameter logic [15:0] STACK_LIMIT = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [15:0] op_data,
  output logic        op_ready,
  input  logic [15:0] pc_value,
  input  logic [15:0] sp_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        sp_push,
  output logic        sp_pop,
  output logic        pc_jump_en,
  output logic [15:0] pc_jump_addr,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic        fault_valid,
  output logic [1:0]  fault_code
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL   = 2'd3;

  typedef enum logic [1:0] {IDLE, MEM, COMMIT, FAULT} state_t;

  state_t      state, next_state;
  logic        accept;
  logic [2:0]  snap_op;
  logic [15:0] snap_data, snap_pc, snap_sp;
  logic [15:0] rdata_q, pop_data_q;
  logic [1:0]  fault_code_q, next_fault_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fault_code_q <= 2'd0;
    end else begin
      state        <= next_state;
      fault_code_q <= next_fault_code;
    end
  end

  // Snapshots freeze the operation at acceptance; the sources may change afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_op    <= OP_NOP;
      snap_data  <= 16'h0000;
      snap_pc    <= 16'h0000;
      snap_sp    <= 16'h0000;
      rdata_q    <= 16'h0000;
      pop_data_q <= 16'h0000;
    end else begin
      if (accept) begin
        snap_op   <= op_code;
        snap_data <= op_data;
        snap_pc   <= pc_value;
        snap_sp   <= sp_value;
      end
      if (state == MEM && mem_ack) begin
        rdata_q <= mem_rdata;
        if (snap_op == OP_POP)
          pop_data_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    next_state      = state;
    next_fault_code = fault_code_q;
    accept          = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          accept = 1'b1;
          case (op_code)
            OP_NOP: next_state = IDLE;
            OP_PUSH, OP_CALL: begin
              if (sp_value == STACK_LIMIT) begin
                next_state      = FAULT;
                next_fault_code = FAULT_OVERFLOW;
              end else begin
                next_state = MEM;
              end
            end
            OP_POP, OP_RET: begin
              if (sp_value == STACK_TOP) begin
                next_state      = FAULT;
                next_fault_code = FAULT_UNDERFLOW;
              end else begin
                next_state = MEM;
              end
            end
            default: begin
              next_state      = FAULT;
              next_fault_code = FAULT_ILLEGAL;
            end
          endcase
        end
      end
      MEM:     if (mem_ack) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every output is decoded from state and snapshot registers only.
  always_comb begin
    op_ready     = (state == IDLE);
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    sp_push      = 1'b0;
    sp_pop       = 1'b0;
    pc_jump_en   = 1'b0;
    pc_jump_addr = 16'h0000;
    pop_valid    = 1'b0;
    fault_valid  = 1'b0;
    case (state)
      MEM: begin
        mem_req = 1'b1;
        case (snap_op)
          OP_PUSH: begin
            mem_we    = 1'b1;
            mem_addr  = snap_sp - 16'd1;
            mem_wdata = snap_data;
          end
          OP_CALL: begin
            mem_we    = 1'b1;
            mem_addr  = snap_sp - 16'd1;
            mem_wdata = snap_pc + 16'd1;
          end
          default: mem_addr = snap_sp;
        endcase
      end
      COMMIT: begin
        case (snap_op)
          OP_PUSH: sp_push = 1'b1;
          OP_CALL: begin
            sp_push      = 1'b1;
            pc_jump_en   = 1'b1;
            pc_jump_addr = snap_data;
          end
          OP_POP: begin
            sp_pop    = 1'b1;
            pop_valid = 1'b1;
          end
          OP_RET: begin
            sp_pop       = 1'b1;
            pc_jump_en   = 1'b1;
            pc_jump_addr = rdata_q;
          end
          default: ;
        endcase
      end
      FAULT: fault_valid = 1'b1;
      default: ;
    endcase
  end

  assign pop_data   = pop_data_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_stack_call_sequencer.sv
// Bench for stack_call_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized operations against a stack/memory reference model.
module tb_stack_call_sequencer;

  localparam logic [15:0] TOP   = 16'h0190;
  localparam logic [15:0] LIMIT = 16'h0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [15:0] op_data;
  logic        op_ready;
  logic [15:0] pc_value, sp_value;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        sp_push, sp_pop, pc_jump_en;
  logic [15:0] pc_jump_addr, pop_data;
  logic        pop_valid, fault_valid;
  logic [1:0]  fault_code;

  stack_call_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_data(op_data),
    .op_ready(op_ready), .pc_value(pc_value), .sp_value(sp_value), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .sp_push(sp_push), .sp_pop(sp_pop), .pc_jump_en(pc_jump_en),
    .pc_jump_addr(pc_jump_addr), .pop_data(pop_data), .pop_valid(pop_valid),
    .fault_valid(fault_valid), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data, pc, sp;
    int          delay;
    logic [15:0] rdata;
    bit          e_fault;
    logic [1:0]  e_code;
    bit          e_mem, e_we;
    logic [15:0] e_addr, e_wdata;
    bit          e_push, e_pop, e_jump;
    logic [15:0] e_jaddr;
    bit          e_popv;
  } vec_t;

  int checks = 0;
  int passes = 0;
  logic [15:0] last_pop;
  logic [1:0]  last_code;
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] model_sp, model_pc;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Expected behaviour of one operation derived from the stack rules.
  function automatic vec_t model_expect(input logic [2:0] op, input logic [15:0] data,
                                        input logic [15:0] pc, input logic [15:0] sp,
                                        input int delay, input logic [15:0] rdata);
    vec_t v;
    v = '{op, data, pc, sp, delay, rdata, 0, 2'd0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0};
    if (op == 3'd1 || op == 3'd3) begin
      if (sp == LIMIT) begin
        v.e_fault = 1; v.e_code = 2'd1;
      end else begin
        v.e_mem = 1; v.e_we = 1; v.e_addr = sp - 16'd1; v.e_push = 1;
        v.e_wdata = (op == 3'd1) ? data : pc + 16'd1;
        v.e_jump = (op == 3'd3); v.e_jaddr = data;
      end
    end else if (op == 3'd2 || op == 3'd4) begin
      if (sp == TOP) begin
        v.e_fault = 1; v.e_code = 2'd2;
      end else begin
        v.e_mem = 1; v.e_addr = sp; v.e_pop = 1;
        v.e_popv = (op == 3'd2); v.e_jump = (op == 3'd4); v.e_jaddr = rdata;
      end
    end else if (op != 3'd0) begin
      v.e_fault = 1; v.e_code = 2'd3;
    end
    return v;
  endfunction

  // Presents one operation at a falling edge (DUT idle) and follows it back to idle.
  task automatic applyStimulus(input vec_t v, input string tag);
    checkOutput({tag, ".op_ready_in"}, op_ready, 1);
    op_valid = 1; op_code = v.op; op_data = v.data; pc_value = v.pc; sp_value = v.sp;
    @(negedge clk);
    op_valid = 0; op_code = 3'($urandom); op_data = 16'($urandom);
    pc_value = 16'($urandom); sp_value = 16'($urandom);
    if (v.e_fault) begin
      last_code = v.e_code;
      checkOutput({tag, ".fault_valid"}, fault_valid, 1);
      checkOutput({tag, ".fault_code"}, fault_code, v.e_code);
      checkOutput({tag, ".fault_req"}, mem_req, 0);
      checkOutput({tag, ".fault_strobes"}, {sp_push, sp_pop, pc_jump_en}, 0);
      @(negedge clk);
      checkOutput({tag, ".fault_ready"}, op_ready, 1);
      checkOutput({tag, ".fault_drop"}, fault_valid, 0);
    end else if (!v.e_mem) begin
      checkOutput({tag, ".nop_ready"}, op_ready, 1);
      checkOutput({tag, ".nop_req"}, mem_req, 0);
      checkOutput({tag, ".nop_strobes"}, {sp_push, sp_pop, pc_jump_en, pop_valid, fault_valid}, 0);
    end else begin
      for (int d = 0; d <= v.delay; d++) begin
        checkOutput($sformatf("%s.mem_req[%0d]", tag, d), mem_req, 1);
        checkOutput($sformatf("%s.mem_we[%0d]", tag, d), mem_we, v.e_we);
        checkOutput($sformatf("%s.mem_addr[%0d]", tag, d), mem_addr, v.e_addr);
        if (v.e_we) checkOutput($sformatf("%s.mem_wdata[%0d]", tag, d), mem_wdata, v.e_wdata);
        checkOutput($sformatf("%s.busy[%0d]", tag, d), {op_ready, sp_push, sp_pop, pc_jump_en}, 0);
        if (d == v.delay) begin
          mem_ack = 1; mem_rdata = v.rdata;
        end
        @(negedge clk);
        mem_ack = 0; mem_rdata = 16'($urandom);
      end
      if (v.e_popv) last_pop = v.rdata;
      checkOutput({tag, ".sp_push"}, sp_push, v.e_push);
      checkOutput({tag, ".sp_pop"}, sp_pop, v.e_pop);
      checkOutput({tag, ".pc_jump_en"}, pc_jump_en, v.e_jump);
      if (v.e_jump) checkOutput({tag, ".pc_jump_addr"}, pc_jump_addr, v.e_jaddr);
      checkOutput({tag, ".pop_valid"}, pop_valid, v.e_popv);
      checkOutput({tag, ".commit_req"}, {mem_req, op_ready}, 0);
      @(negedge clk);
      checkOutput({tag, ".ready_back"}, op_ready, 1);
      checkOutput({tag, ".strobes_off"}, {sp_push, sp_pop, pc_jump_en, pop_valid}, 0);
    end
    checkOutput({tag, ".pop_data_hold"}, pop_data, last_pop);
    checkOutput({tag, ".fault_code_hold"}, fault_code, last_code);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[14];
    vec_t v;
    logic [2:0] op;
    logic [15:0] sp, rd;
    int r;

    vecs[0]  = '{3'd1, 16'hBEEF, 16'h0000, 16'h0190, 0, 16'h0000, 0, 2'd0, 1, 1, 16'h018F, 16'hBEEF, 1, 0, 0, 16'h0000, 0};
    vecs[1]  = '{3'd3, 16'h0040, 16'h0012, 16'h018F, 3, 16'h0000, 0, 2'd0, 1, 1, 16'h018E, 16'h0013, 1, 0, 1, 16'h0040, 0};
    vecs[2]  = '{3'd4, 16'h7777, 16'h0040, 16'h018E, 1, 16'h0013, 0, 2'd0, 1, 0, 16'h018E, 16'h0000, 0, 1, 1, 16'h0013, 0};
    vecs[3]  = '{3'd2, 16'h0000, 16'h0013, 16'h018F, 0, 16'hBEEF, 0, 2'd0, 1, 0, 16'h018F, 16'h0000, 0, 1, 0, 16'h0000, 1};
    vecs[4]  = '{3'd2, 16'h0000, 16'h0014, 16'h0190, 0, 16'h0000, 1, 2'd2, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    vecs[5]  = '{3'd1, 16'h1111, 16'h0015, 16'h0100, 0, 16'h0000, 1, 2'd1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    vecs[6]  = '{3'd6, 16'h2222, 16'h0016, 16'h0150, 0, 16'h0000, 1, 2'd3, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    vecs[7]  = '{3'd3, 16'h1234, 16'hFFFF, 16'h0101, 2, 16'h0000, 0, 2'd0, 1, 1, 16'h0100, 16'h0000, 1, 0, 1, 16'h1234, 0};
    vecs[8]  = '{3'd4, 16'h0000, 16'h1234, 16'h0100, 0, 16'h0000, 0, 2'd0, 1, 0, 16'h0100, 16'h0000, 0, 1, 1, 16'h0000, 0};
    vecs[9]  = '{3'd0, 16'hAAAA, 16'h0001, 16'h0150, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    vecs[10] = '{3'd7, 16'h0000, 16'h0002, 16'h0190, 0, 16'h0000, 1, 2'd3, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    vecs[11] = '{3'd3, 16'h0800, 16'h0003, 16'h0100, 0, 16'h0000, 1, 2'd1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    vecs[12] = '{3'd4, 16'h0000, 16'h0004, 16'h0190, 0, 16'h0000, 1, 2'd2, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};
    vecs[13] = '{3'd5, 16'h0000, 16'h0005, 16'h0120, 0, 16'h0000, 1, 2'd3, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0};

    reset = 0; op_valid = 0; op_code = 0; op_data = 0; pc_value = 0; sp_value = 0;
    mem_ack = 0; mem_rdata = 0;
    last_pop = 16'h0000; last_code = 2'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst.mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    checkOutput("rst.strobes", {sp_push, sp_pop, pc_jump_en, pop_valid, fault_valid}, 0);
    checkOutput("rst.pc_jump_addr", pc_jump_addr, 0);
    checkOutput("rst.pop_data", pop_data, 0);
    checkOutput("rst.fault_code", fault_code, 0);
    reset = 1;
    @(negedge clk);
    checkOutput("rst.op_ready", op_ready, 1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] reset during memory access");
    op_valid = 1; op_code = 3'd1; op_data = 16'h4321; sp_value = 16'h0180;
    @(negedge clk);
    op_valid = 0;
    checkOutput("arst.req_before", mem_req, 1);
    #1 reset = 0;
    #1;
    checkOutput("arst.req_async_drop", {mem_req, mem_we, mem_addr}, 0);
    checkOutput("arst.strobes_async", {sp_push, sp_pop, pc_jump_en, fault_valid}, 0);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    checkOutput("arst.no_commit", {mem_req, sp_push, sp_pop, pc_jump_en, pop_valid}, 0);
    reset = 1;
    last_pop = 16'h0000; last_code = 2'd0;
    @(negedge clk);
    checkOutput("arst.ready_after", op_ready, 1);
    checkOutput("arst.pop_data_cleared", pop_data, 0);
    applyStimulus(vecs[0], "arst.push");

    $display("[TB] spurious ack and back-to-back NOPs");
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1; mem_rdata = 16'hDEAD;
      op_valid = (i >= 2); op_code = 3'd0; sp_value = 16'h0190;
      @(negedge clk);
      checkOutput($sformatf("idle.ready[%0d]", i), op_ready, 1);
      checkOutput($sformatf("idle.quiet[%0d]", i), {mem_req, sp_push, sp_pop, pc_jump_en, pop_valid, fault_valid}, 0);
    end
    mem_ack = 0; op_valid = 0;
    checkOutput("idle.pop_data", pop_data, last_pop);

    $display("[TB] randomized operations");
    model_sp = TOP; model_pc = 16'h0200;
    for (int i = 0; i < 90; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0 || r == 15) op = 3'd0;
      else if (r == 1) op = 3'($urandom_range(5, 7));
      else if (r <= 5) op = 3'd1;
      else if (r <= 8) op = 3'd2;
      else if (r <= 11) op = 3'd3;
      else op = 3'd4;
      sp = model_sp;
      case ($urandom_range(0, 11))
        0: sp = LIMIT;
        1: sp = TOP;
        2: sp = LIMIT + 16'd1;
        default: ;
      endcase
      rd = mem_model.exists(sp) ? mem_model[sp] : 16'($urandom);
      v = model_expect(op, 16'($urandom), model_pc, sp, $urandom_range(0, 3), rd);
      applyStimulus(v, $sformatf("rnd%0d", i));
      if (v.e_push) begin
        mem_model[v.e_addr] = v.e_wdata;
        model_sp = sp - 16'd1;
      end else if (v.e_pop) begin
        model_sp = sp + 16'd1;
      end else begin
        model_sp = sp;
      end
      model_pc = v.e_jump ? v.e_jaddr : model_pc + 16'd1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stack_call_sequencer.md
# stack_call_sequencer

Sequencer that executes stack-class instructions (PUSH, POP, CALL, RET) against the program counter and stack pointer registers and the shared data memory port. It sits between instruction decode and the PC/SP register pair. For each operation it:
- issues one handshaked memory access;
- pulses the SP push/pop strobes and PC jump load in a single commit cycle;
- flags stack overflow, stack underflow and illegal opcodes without touching any state.

## Interface
- STACK_TOP, 16'h0190, SP value when the stack is empty (matches SP reset value)
- STACK_LIMIT, 16'h0100, lowest legal SP; SP == STACK_LIMIT means full
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low
- op_valid  input  1  decode presents an operation
- op_code  input  3  0=NOP, 1=PUSH, 2=POP, 3=CALL, 4=RET, 5..7 illegal
- op_data  input  16  PUSH data or CALL target
- op_ready  output  1  sequencer can accept; operation accepted when op_valid && op_ready
- pc_value  input  16  current PC register value
- sp_value  input  16  current SP register value
- mem_req  output  1  memory access request, held until mem_ack
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  16  access address
- mem_wdata  output  16  write data
- mem_ack  input  1  memory completes access in this cycle
- mem_rdata  input  16  read data, valid in the mem_ack cycle
- sp_push  output  1  one-cycle strobe, SP decrements
- sp_pop  output  1  one-cycle strobe, SP increments
- pc_jump_en  output  1  one-cycle strobe, PC loads pc_jump_addr
- pc_jump_addr  output  16  jump target
- pop_data  output  16  data from the last POP; holds until the next POP
- pop_valid  output  1  one-cycle strobe qualifying pop_data
- fault_valid  output  1  one-cycle fault strobe
- fault_code  output  2  1=overflow, 2=underflow, 3=illegal; held until the next fault

## Operation
- States: IDLE, MEM, COMMIT, FAULT. op_ready = (state == IDLE).
- On acceptance, latch op_code, op_data, pc_value, sp_value into snapshot registers. Later cycles use only the snapshots.
- Stack convention is full-descending:
  - PUSH/CALL write to snap_sp-1.
  - POP/RET read from snap_sp.
- IDLE acceptance:
  - NOP: stay IDLE, no outputs.
  - Illegal opcode: go to FAULT, code 3.
  - PUSH or CALL with snap_sp == STACK_LIMIT: go to FAULT, code 1.
  - POP or RET with snap_sp == STACK_TOP: go to FAULT, code 2.
  - Otherwise: go to MEM.
- MEM:
  - mem_req=1; mem_addr, mem_we and mem_wdata stay stable until the ack.
  - PUSH: we=1, addr=snap_sp-1, wdata=snap_data.
  - CALL: we=1, addr=snap_sp-1, wdata=snap_pc+1 (16-bit wrap, 16'hFFFF+1 = 0).
  - POP and RET: we=0, addr=snap_sp.
  - On mem_ack: capture mem_rdata (reads), go to COMMIT.
- COMMIT, single cycle, then IDLE:
  - PUSH: sp_push.
  - CALL: sp_push and pc_jump_en with pc_jump_addr=snap_data.
  - POP: sp_pop, pop_valid, pop_data=captured rdata.
  - RET: sp_pop and pc_jump_en with pc_jump_addr=captured rdata.
- FAULT: single cycle with fault_valid=1, then IDLE. No memory access, SP/PC strobes stay 0.
- sp_push and sp_pop are never both 1.
- mem_ack outside MEM is ignored.
- Reset asserted mid-operation: state goes to IDLE immediately (asynchronous). mem_req and all strobes drop immediately; the in-flight operation is abandoned with no commit.

## Timing
- Reset values: state IDLE, op_ready=1 (once reset is released), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, sp_push=0, sp_pop=0, pc_jump_en=0, pc_jump_addr=0, pop_data=0, pop_valid=0, fault_valid=0, fault_code=0.
- Accept at cycle T:
  - mem_req rises at T+1.
  - Ack at cycle A (A ≥ T+1) gives COMMIT strobes at A+1.
  - op_ready returns at A+2.
  - Minimum issue interval is 3 cycles.
- Fault path: accept at T, fault_valid at T+1, op_ready at T+2.
- NOP path: op_ready stays 1, so back-to-back NOPs are accepted every cycle.
- All outputs are registered or decoded from state/snapshot registers; no combinational path from op_* or mem_ack to outputs.

## Test plan
- PUSH 16'hBEEF with sp=16'h0190, ack same cycle as req -> write at 16'h018F, data BEEF; sp_push pulse at T+2; op_ready at T+3.
- CALL target 16'h0040, pc=16'h0012, sp=16'h018F, ack delayed 3 cycles -> mem_req held 4 cycles, write 16'h0013 at 16'h018E; sp_push and pc_jump_en with addr 16'h0040 in the same cycle.
- RET with sp=16'h018E, rdata=16'h0013 -> read at 16'h018E; sp_pop and pc_jump_en with addr 16'h0013. POP then returns pop_data with pop_valid.
- POP with sp=16'h0190 -> fault_valid at T+1, code 2, no mem_req. PUSH with sp=16'h0100 -> code 1. op_code 6 -> code 3.
- Reset pulled low while mem_req=1 -> mem_req drops asynchronously, no strobes. After release: op_ready=1, next PUSH proceeds normally.
- Spurious mem_ack in IDLE and back-to-back NOPs -> no state change, op_ready constant 1.
